phy_rx: RTL and testbench
=========================

# phy_rx

Receive-side PHY for the two-lane serial link: per-lane serial-to-parallel conversion, comma-based byte alignment and lock, and recovery of one byte stream per lane. Sits at the far end of the link from the transmit PHY and accepts its two serial lanes, MSB first, one bit per `clk_8f` cycle, with 0xBC sent as the idle/sync byte whenever the transmitter has no valid data. Runs entirely in the `clk_8f` domain. Byte-rate events are internal 1-in-8 strobes, not derived clocks.

## Interface
- `COMMA`, 8'hBC: idle/sync byte. Never delivered as data.
- `LOCK_COUNT`, 4: consecutive aligned commas required for lock. Legal range 1..15.
- `clk_8f`  input  1  bit-rate clock. All state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in_0`  input  1  serial lane 0, MSB first.
- `data_in_1`  input  1  serial lane 1, MSB first.
- `data_out_0`  output  8  last data byte received on lane 0.
- `valid_out_0`  output  1  one-cycle pulse: `data_out_0` updated this cycle.
- `data_out_1`  output  8  last data byte received on lane 1.
- `valid_out_1`  output  1  one-cycle pulse: `data_out_1` updated this cycle.
- `active_0`, `active_1`  output  1  lane locked.
- `active`  output  1  `active_0 & active_1`; link up.

## Operation
- Each lane is an identical, independent instance. Per lane:
  - Shift register `sr[7:0]`, every cycle: `sr <= {sr[6:0], din}`.
  - Candidate byte `nb = {sr[6:0], din}`.
  - 3-bit phase counter `ph`.
  - 4-bit comma counter `cnt`.
  - FSM states: SEARCH, COUNT, LOCKED.
- A boundary is a cycle where `ph == 7`; `ph` increments mod 8 every cycle outside SEARCH.
- SEARCH: checks `nb` every cycle.
  - If `nb == COMMA`, set `ph <= 0` and `cnt <= 1`. Go to LOCKED if `LOCK_COUNT == 1`, otherwise go to COUNT.
- COUNT: acts only at boundaries.
  - If `nb == COMMA`, increment `cnt`. When `cnt+1 == LOCK_COUNT`, go to LOCKED.
  - If `nb != COMMA`, go to SEARCH with `cnt <= 0`. That byte is not delivered.
- LOCKED: acts only at boundaries.
  - If `nb == COMMA`, no output; `valid_out` stays 0.
  - Otherwise `data_out <= nb` and `valid_out <= 1` for exactly one cycle.
  - LOCKED is left only through `reset`.
- Lane data is delivered only while `active` is 1. A lane that is locked while the other lane is not discards its data bytes: no valid pulse, `data_out` unchanged.
- `active_x` is 1 exactly while the lane FSM is in LOCKED.
- `data_out_x` holds its value between pulses.

## Timing
- Reset (asynchronous, immediate, also mid-byte or mid-lock):
  - `sr`, `ph`, `cnt` cleared; FSM to SEARCH.
  - All outputs 0: `data_out_x = 8'h00`, `valid_out_x = 0`, `active_x = 0`, `active = 0`.
  - Re-lock requires a fresh `LOCK_COUNT` commas after reset deasserts.
- Lock latency: `active_x` rises on the edge that samples the last bit of the `LOCK_COUNT`-th aligned comma, i.e. visible the cycle after that bit is on `din`.
- Data latency: the last (LSB) bit of a data byte on `din` in cycle t gives `valid_out_x = 1` and the new `data_out_x` in cycle t+1. Back-to-back data bytes give a pulse every 8 cycles.
- Bit slip before lock is absorbed: alignment is taken from the first comma found at any bit offset.
- Lanes use independent alignment. If the lanes are skewed by k bits, their valid pulses are k cycles apart; no deskew.
- A comma pattern straddling a boundary while in LOCKED is ignored. Alignment is never re-acquired without reset.

## Test plan
- Reset: assert `reset` mid-stream -> all outputs 0 within the same cycle, no valid pulse after deassert until 4 new commas are received.
- Lock and data: both lanes send BC,BC,BC,BC, then 0x5A on lane 0 and 0xA5 on lane 1 -> `active` rises after the 4th BC; `valid_out_0`/`valid_out_1` pulse together one cycle after the last bit, carrying 0x5A/0xA5; both pulses last one cycle.
- Short preamble: BC,BC,BC,0x00, then BC x4 and 0x11 -> no lock after the 0x00, FSM returns to SEARCH; the later 0x11 is delivered once.
- Bit slip: 3 random bits, then BC x4 and 0xC3 -> correct alignment, 0xC3 output.
- Idle in data: BC x4, 0x01, BC, 0x02 -> exactly two pulses, 16 cycles apart, carrying 0x01 and 0x02; `data_out` holds 0x01 during the BC byte.
- One lane locked: lane 0 sends BC x4 + 0x77 while lane 1 sends all zeros -> `active_0 = 1`, `active = 0`, no `valid_out_0` pulse, `data_out_0` stays 0x00.

Source files
------------

// File: rtl/phy_rx.sv
// Two-lane receive PHY: per-lane deserialisation, comma alignment/lock and
// byte recovery. Data is only released while both lanes are locked.

module phy_rx_lane #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] nb,
  output logic       byte_stb,
  output logic       locked
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] ph_q, ph_d;
  logic [3:0] cnt_q, cnt_d;
  logic       boundary;
  logic       is_comma;

  assign nb       = {sr_q[6:0], din};
  assign sr_d     = nb;
  assign boundary = (ph_q == 3'd7);
  assign is_comma = (nb == COMMA);
  assign locked   = (state_q == LOCKED);

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    byte_stb = 1'b0;
    // Phase only free-runs once an alignment has been chosen.
    if (state_q != SEARCH) begin
      ph_d = ph_q + 3'd1;
    end
    case (state_q)
      SEARCH: begin
        if (is_comma) begin
          ph_d    = 3'd0;
          cnt_d   = 4'd1;
          state_d = (LOCK_N == 4'd1) ? LOCKED : COUNT;
        end
      end
      COUNT: begin
        if (boundary) begin
          if (is_comma) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = SEARCH;
          end
        end
      end
      LOCKED: begin
        // Alignment is frozen here; only a reset can drop lock.
        byte_stb = boundary && !is_comma;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      sr_q    <= 8'h00;
      ph_q    <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

module phy_rx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in_0,
  input  logic       data_in_1,
  output logic [7:0] data_out_0,
  output logic       valid_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_1,
  output logic       active_0,
  output logic       active_1,
  output logic       active
);

  logic [7:0] nb_0, nb_1;
  logic       stb_0, stb_1;
  logic       locked_0, locked_1;

  logic [7:0] data_0_q, data_0_d;
  logic [7:0] data_1_q, data_1_d;
  logic       valid_0_q, valid_0_d;
  logic       valid_1_q, valid_1_d;

  phy_rx_lane #(
    .COMMA     (COMMA),
    .LOCK_COUNT(LOCK_COUNT)
  ) u_lane_0 (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .din     (data_in_0),
    .nb      (nb_0),
    .byte_stb(stb_0),
    .locked  (locked_0)
  );

  phy_rx_lane #(
    .COMMA     (COMMA),
    .LOCK_COUNT(LOCK_COUNT)
  ) u_lane_1 (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .din     (data_in_1),
    .nb      (nb_1),
    .byte_stb(stb_1),
    .locked  (locked_1)
  );

  // A lane's bytes are dropped until the link as a whole is up.
  always_comb begin
    valid_0_d = stb_0 & locked_0 & locked_1;
    valid_1_d = stb_1 & locked_0 & locked_1;
    data_0_d  = valid_0_d ? nb_0 : data_0_q;
    data_1_d  = valid_1_d ? nb_1 : data_1_q;
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      data_0_q  <= 8'h00;
      data_1_q  <= 8'h00;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
    end else begin
      data_0_q  <= data_0_d;
      data_1_q  <= data_1_d;
      valid_0_q <= valid_0_d;
      valid_1_q <= valid_1_d;
    end
  end

  assign data_out_0  = data_0_q;
  assign data_out_1  = data_1_q;
  assign valid_out_0 = valid_0_q;
  assign valid_out_1 = valid_1_q;
  assign active_0    = locked_0;
  assign active_1    = locked_1;
  assign active      = locked_0 & locked_1;

endmodule

// File: tb/tb_phy_rx.sv
// Bench for phy_rx: directed and randomised lane streams checked cycle by
// cycle against a stream-level lock/delivery model.

module tb_phy_rx;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;

  logic       clk_8f    = 1'b0;
  logic       reset     = 1'b1;
  logic       data_in_0 = 1'b0;
  logic       data_in_1 = 1'b0;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1;
  logic       active_0, active_1, active;

  int n_tests = 0;
  int n_fail  = 0;

  bit          s0[$];
  bit          s1[$];
  int          lock_at[2];
  logic [20:0] exp_vec[$];

  phy_rx #(
    .COMMA     (COMMA),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .data_out_0 (data_out_0),
    .valid_out_0(valid_out_0),
    .data_out_1 (data_out_1),
    .valid_out_1(valid_out_1),
    .active_0   (active_0),
    .active_1   (active_1),
    .active     (active)
  );

  always #5 clk_8f = ~clk_8f;

  function automatic logic [23:0] dut_vec();
    return {3'b000, active, active_1, active_0, valid_out_1, valid_out_0,
            data_out_1, data_out_0};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) s0.push_back(b[i]);
      else           s1.push_back(b[i]);
    end
  endtask

  task automatic push_both(input logic [7:0] b);
    push_byte(0, b);
    push_byte(1, b);
  endtask

  task automatic push_rand_bits(input int lane, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (lane == 0) s0.push_back(1'($urandom));
      else           s1.push_back(1'($urandom));
    end
  endtask

  // Byte seen on a lane when bit i is the newest bit; bits before the
  // stream start are the zeros left by reset.
  function automatic logic [7:0] byte_at(input int lane, input int i);
    logic [7:0] v;
    logic       b;
    v = 8'h00;
    for (int j = i - 7; j <= i; j++) begin
      if (j < 0)          b = 1'b0;
      else if (lane == 0) b = s0[j];
      else                b = s1[j];
      v = {v[6:0], b};
    end
    return v;
  endfunction

  // Index of the bit whose sampling completes lock, or -1 if never locked.
  function automatic int find_lock(input int lane, input int n);
    int pos;
    int j;
    int c;
    pos = 0;
    while (pos < n) begin
      if (byte_at(lane, pos) == COMMA) begin
        c = 1;
        j = pos;
        while (c < LOCK_COUNT && j + 8 < n && byte_at(lane, j + 8) == COMMA) begin
          j += 8;
          c++;
        end
        if (c >= LOCK_COUNT) return j;
        if (j + 8 >= n) return -1;
        pos = j + 9;
      end else begin
        pos++;
      end
    end
    return -1;
  endfunction

  task automatic build_model();
    int         n;
    int         o;
    logic [7:0] cur[2];
    logic       v[2];
    logic       a[2];
    while (s0.size() < s1.size()) s0.push_back(1'b0);
    while (s1.size() < s0.size()) s1.push_back(1'b0);
    n = s0.size();
    lock_at[0] = find_lock(0, n);
    lock_at[1] = find_lock(1, n);
    cur[0] = 8'h00;
    cur[1] = 8'h00;
    exp_vec.delete();
    for (int k = 0; k < n; k++) begin
      for (int x = 0; x < 2; x++) begin
        o    = 1 - x;
        a[x] = (lock_at[x] >= 0) && (k >= lock_at[x]);
        v[x] = 1'b0;
        if (lock_at[x] >= 0 && k > lock_at[x] && ((k - lock_at[x]) % 8) == 0 &&
            byte_at(x, k) != COMMA && lock_at[o] >= 0 && lock_at[o] < k) begin
          v[x]   = 1'b1;
          cur[x] = byte_at(x, k);
        end
      end
      exp_vec.push_back({a[0] & a[1], a[1], a[0], v[1], v[0], cur[1], cur[0]});
    end
  endtask

  task automatic run_scn(input string name, input int want0, input int want1);
    int p0;
    int p1;
    p0 = 0;
    p1 = 0;
    build_model();
    for (int k = 0; k < exp_vec.size(); k++) begin
      data_in_0 = s0[k];
      data_in_1 = s1[k];
      @(posedge clk_8f);
      #1;
      check($sformatf("%s[%0d]", name, k), dut_vec(), {3'b000, exp_vec[k]});
      if (valid_out_0 === 1'b1) p0++;
      if (valid_out_1 === 1'b1) p1++;
    end
    if (want0 >= 0) check({name, "/pulses0"}, 24'(p0), 24'(want0));
    if (want1 >= 0) check({name, "/pulses1"}, 24'(p1), 24'(want1));
    s0.delete();
    s1.delete();
  endtask

  // Reset lands mid-cycle and must clear the outputs before the next edge.
  task automatic do_reset(input string name);
    @(posedge clk_8f);
    #3;
    reset = 1'b1;
    #1;
    check({name, "/async_reset"}, dut_vec(), 24'h0);
    @(posedge clk_8f);
    #1;
    reset     = 1'b0;
    data_in_0 = 1'b0;
    data_in_1 = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    repeat (2) @(posedge clk_8f);
    #1;
    check("reset_state", dut_vec(), 24'h0);
    reset = 1'b0;

    repeat (4) push_both(COMMA);
    push_byte(0, 8'h5A);
    push_byte(1, 8'hA5);
    push_both(COMMA);
    run_scn("lock_data", 1, 1);
    do_reset("after_lock_data");

    repeat (3) push_both(COMMA);
    push_both(8'h00);
    repeat (4) push_both(COMMA);
    push_byte(0, 8'h11);
    push_byte(1, 8'h22);
    push_both(COMMA);
    run_scn("short_preamble", 1, 1);
    do_reset("after_short");

    push_rand_bits(0, 3);
    push_rand_bits(1, $urandom_range(0, 7));
    repeat (4) push_both(COMMA);
    push_byte(0, 8'hC3);
    rb = 8'($urandom);
    if (rb == COMMA) rb = 8'h3C;
    push_byte(1, rb);
    push_both(COMMA);
    push_both(COMMA);
    run_scn("bit_slip", 1, 1);
    do_reset("after_slip");

    repeat (4) push_both(COMMA);
    push_both(8'h01);
    push_both(COMMA);
    push_both(8'h02);
    push_both(COMMA);
    run_scn("idle_in_data", 2, 2);
    do_reset("after_idle");

    repeat (4) push_byte(0, COMMA);
    push_byte(0, 8'h77);
    push_byte(0, COMMA);
    repeat (6) push_byte(1, 8'h00);
    run_scn("one_lane", 0, 0);
    do_reset("after_one_lane");

    for (int r = 0; r < 3; r++) begin
      push_rand_bits(0, $urandom_range(0, 7));
      push_rand_bits(1, $urandom_range(0, 7));
      repeat (4) push_both(COMMA);
      for (int i = 0; i < 24; i++) begin
        for (int ln = 0; ln < 2; ln++) begin
          rb = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom);
          push_byte(ln, rb);
        end
      end
      push_both(COMMA);
      run_scn($sformatf("random%0d", r), -1, -1);
      do_reset($sformatf("after_random%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
